// File: rtl/cordic_iter_ctrl.sv
// Iterative rotation-mode CORDIC sequencer driving external X/Y update units; owns Z, atan table, quadrant fold.
// Latency: Start edge E0 -> Done in the cycle after edge E0+ITER+1; Start ignored while busy except on the Done cycle.
module cordic_iter_ctrl #(
   parameter int WIDTH  = 16,
   parameter int ITER   = 16,
   parameter int K_INIT = 9949
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] angle_in,
   input  logic [WIDTH-1:0] cordic_x_i,
   input  logic [WIDTH-1:0] cordic_y_i,
   output logic [WIDTH-1:0] x_o,
   output logic [WIDTH-1:0] y_o,
   output logic [WIDTH-1:0] shifted_x,
   output logic [WIDTH-1:0] shifted_y,
   output logic             enable,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sin_out,
   output logic [WIDTH-1:0] cos_out
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROT, S_FIN} state_t;

   localparam logic [3:0]       ILAST = 4'(ITER - 1);
   localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};

   state_t           state, state_nxt;
   logic [WIDTH-1:0] ang, x, y, z;
   logic [3:0]       idx;
   logic             neg;

   function automatic logic [WIDTH-1:0] atan_lut(input logic [3:0] k);
      int t;
      t = 0;
      case (k)
         4'd0:  t = 8192;
         4'd1:  t = 4836;
         4'd2:  t = 2555;
         4'd3:  t = 1297;
         4'd4:  t = 651;
         4'd5:  t = 326;
         4'd6:  t = 163;
         4'd7:  t = 81;
         4'd8:  t = 41;
         4'd9:  t = 20;
         4'd10: t = 10;
         4'd11: t = 5;
         4'd12: t = 3;
         4'd13: t = 1;
         4'd14: t = 1;
         default: t = 0;
      endcase
      return WIDTH'(t);
   endfunction

   // -(-max negative) cannot be represented, so clamp it to the largest positive value
   function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] v);
      if (v == MIN_V) return MAX_V;
      return -v;
   endfunction

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = S_LOAD;
         S_LOAD: state_nxt = S_ROT;
         S_ROT:  if (idx == ILAST) state_nxt = S_FIN;
         S_FIN:  state_nxt = start ? S_LOAD : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_FIN);
   assign x_o       = x;
   assign y_o       = y;
   assign shifted_x = $signed(x) >>> idx;
   assign shifted_y = $signed(y) >>> idx;
   assign enable    = z[WIDTH-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         ang     <= '0;
         x       <= '0;
         y       <= '0;
         z       <= '0;
         idx     <= '0;
         neg     <= 1'b0;
         sin_out <= '0;
         cos_out <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: if (start) ang <= angle_in;
            S_LOAD: begin
               // outside +/-pi/2: rotate by pi, then flip the signs of both results at the end
               if (ang[WIDTH-1] ^ ang[WIDTH-2]) begin
                  z   <= ang ^ MIN_V;
                  neg <= 1'b1;
               end else begin
                  z   <= ang;
                  neg <= 1'b0;
               end
               x   <= WIDTH'(K_INIT);
               y   <= '0;
               idx <= '0;
            end
            S_ROT: begin
               x   <= cordic_x_i;
               y   <= cordic_y_i;
               z   <= enable ? (z + atan_lut(idx)) : (z - atan_lut(idx));
               idx <= (idx == ILAST) ? 4'd0 : idx + 4'd1;
            end
            S_FIN: begin
               sin_out <= neg ? sat_neg(y) : y;
               cos_out <= neg ? sat_neg(x) : x;
               if (start) ang <= angle_in;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for cordic_iter_ctrl with a behavioural model of the saturating X/Y update units.
module tb_cordic_iter_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] angle_in;
   logic [15:0] cx, cy;
   logic [15:0] x_o, y_o, shifted_x, shifted_y;
   logic        enable, busy, done;
   logic [15:0] sin_out, cos_out;

   int checks = 0;
   int errors = 0;

   cordic_iter_ctrl #(.WIDTH(16), .ITER(16), .K_INIT(9949)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .angle_in   (angle_in),
      .cordic_x_i (cx),
      .cordic_y_i (cy),
      .x_o        (x_o),
      .y_o        (y_o),
      .shifted_x  (shifted_x),
      .shifted_y  (shifted_y),
      .enable     (enable),
      .busy       (busy),
      .done       (done),
      .sin_out    (sin_out),
      .cos_out    (cos_out)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] sat17(input logic signed [16:0] v);
      if (v > 17'sd32767)  return 16'h7FFF;
      if (v < -17'sd32768) return 16'h8000;
      return v[15:0];
   endfunction

   // external update units
   always_comb begin
      logic signed [16:0] xs, ys;
      if (enable) begin
         ys = $signed({y_o[15], y_o}) - $signed({shifted_x[15], shifted_x});
         xs = $signed({x_o[15], x_o}) + $signed({shifted_y[15], shifted_y});
      end else begin
         ys = $signed({y_o[15], y_o}) + $signed({shifted_x[15], shifted_x});
         xs = $signed({x_o[15], x_o}) - $signed({shifted_y[15], shifted_y});
      end
      cx = sat17(xs);
      cy = sat17(ys);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_near(input string tag, input int obs, input int exp);
      bit ok;
      ok = ((obs - exp) <= 8) && ((exp - obs) <= 8);
      checks++;
      assert (ok === 1'b1) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d (+/-8)", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [15:0] a);
      angle_in = a;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   // Called just after the Start edge; returns positioned in the Done cycle.
   task automatic wait_done(input string tag, input bit probe, input int rep1, input int rep2);
      int n;
      int bc;
      n  = 0;
      bc = (busy === 1'b1) ? 1 : 0;
      while (done !== 1'b1 && n < 40) begin
         if (n == rep1 || n == rep2) begin
            start    = 1'b1;
            angle_in = 16'hC000;
         end
         tick();
         start = 1'b0;
         n++;
         if (busy === 1'b1) bc++;
         if (probe && n == 1) begin
            chk({tag, " rot0 x"}, int'(x_o), 9949);
            chk({tag, " rot0 y"}, int'(y_o), 0);
            chk({tag, " rot0 sx"}, int'(shifted_x), 9949);
            chk({tag, " rot0 en"}, int'(enable), 0);
         end
         if (probe && n == 2) begin
            chk({tag, " rot1 y"}, int'(y_o), 9949);
            chk({tag, " rot1 sy"}, int'(shifted_y), 4974);
            chk({tag, " rot1 en"}, int'(enable), 1);
         end
      end
      chk({tag, " latency"}, n, 17);
      chk({tag, " busy cycles"}, bc, 18);
   endtask

   task automatic finish_check(input string tag, input int es, input int ec);
      tick();
      chk({tag, " done drop"}, int'(done), 0);
      chk({tag, " busy drop"}, int'(busy), 0);
      chk_near({tag, " sin"}, int'($signed(sin_out)), es);
      chk_near({tag, " cos"}, int'($signed(cos_out)), ec);
   endtask

   task automatic run(input string tag, input logic [15:0] a, input int es, input int ec);
      start_op(a);
      wait_done(tag, 1'b0, -1, -1);
      finish_check(tag, es, ec);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      angle_in = 16'h0000;
      tick();
      tick();
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset sin", int'(sin_out), 0);
      chk("reset cos", int'(cos_out), 0);
      chk("reset x", int'(x_o), 0);
      chk("reset y", int'(y_o), 0);
      rst = 1'b0;
      tick();

      start_op(16'd0);
      wait_done("ang0", 1'b1, -1, -1);
      finish_check("ang0", 0, 16384);

      run("ang45", 16'd8192, 11585, 11585);
      run("ang90", 16'd16384, 16384, 0);
      run("angm90", 16'hC000, -16384, 0);
      run("ang135", 16'd24576, 11585, -11585);
      run("ang180", 16'h8000, 0, -16384);

      // Start re-pulses mid-run ignored, then back-to-back Start on the Done cycle
      start_op(16'd8192);
      wait_done("repulse", 1'b0, 3, 10);
      angle_in = 16'd24576;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      chk("b2b busy", int'(busy), 1);
      chk_near("repulse sin", int'($signed(sin_out)), 11585);
      chk_near("repulse cos", int'($signed(cos_out)), 11585);
      wait_done("b2b", 1'b0, -1, -1);
      finish_check("b2b", 11585, -11585);

      // reset during ROT iteration 7
      start_op(16'd8192);
      repeat (8) tick();
      chk("pre-reset busy", int'(busy), 1);
      rst = 1'b1;
      #1;
      chk("midrst busy", int'(busy), 0);
      chk("midrst done", int'(done), 0);
      chk("midrst sin", int'(sin_out), 0);
      chk("midrst cos", int'(cos_out), 0);
      chk("midrst x", int'(x_o), 0);
      tick();
      rst = 1'b0;
      tick();

      // Start together with reset is dropped
      rst      = 1'b1;
      start    = 1'b1;
      angle_in = 16'd8192;
      tick();
      chk("rst+start busy", int'(busy), 0);
      rst   = 1'b0;
      start = 1'b0;
      tick();
      chk("rst+start idle", int'(busy), 0);

      run("after rst", 16'd8192, 11585, 11585);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
